// File: rtl/ysyx_23060171_wbu_pipe.sv
// ----------------------------------------------------------------------------
// ysyx_23060171_wbu_pipe
//
// Registered, handshaked write-back stage. It holds one retiring instruction
// from the LSU. When the downstream consumer accepts it, the stage commits
// the instruction. On commit it issues the GPR write and the CSR write at
// most once each, and it counts every retired instruction that did not trap.
//
// Ports
//   clock, reset     : clock, synchronous active-high reset
//   in_valid/ready   : LSU -> WBU handshake
//   in_rd1 .. in_memr: operand and result values (XLEN)
//   in_rw, in_crw    : GPR and CSR destination addresses
//   in_irq           : this instruction traps; pc is written to MEPC_ADDR
//   in_reg_sel       : GPR data select (alu/imm/pc+4/memr/crd1)
//   in_csr_sel       : CSR data select (write/set/-/clear)
//   in_reg_we        : GPR write enable
//   in_csr_we        : CSR write enable
//   rf_*             : GPR write port (strobe is one cycle, on commit)
//   csr_*            : CSR write port (strobe is one cycle, on commit)
//   commit_valid/ready, commit_pc : commit handshake toward trace/difftest
//   instret          : retired-instruction counter, wraps modulo 2^CNT_W
// ----------------------------------------------------------------------------
module ysyx_23060171_wbu_pipe #(
    parameter int          XLEN      = 32,
    parameter int          RA_W      = 5,
    parameter int          CNT_W     = 64,
    parameter logic [11:0] MEPC_ADDR = 12'h341
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_rd1,
    input  logic [XLEN-1:0]  in_alu,
    input  logic [XLEN-1:0]  in_crd1,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [XLEN-1:0]  in_imm,
    input  logic [XLEN-1:0]  in_memr,
    input  logic [RA_W-1:0]  in_rw,
    input  logic [11:0]      in_crw,
    input  logic             in_irq,
    input  logic [2:0]       in_reg_sel,
    input  logic [1:0]       in_csr_sel,
    input  logic             in_reg_we,
    input  logic             in_csr_we,
    output logic [XLEN-1:0]  rf_wdata,
    output logic [RA_W-1:0]  rf_waddr,
    output logic             rf_we,
    output logic [XLEN-1:0]  csr_wdata,
    output logic [11:0]      csr_waddr,
    output logic             csr_we,
    output logic             commit_valid,
    input  logic             commit_ready,
    output logic [XLEN-1:0]  commit_pc,
    output logic [CNT_W-1:0] instret
);

    // GPR data select encodings; 101..111 are illegal and suppress the write.
    localparam logic [2:0] RS_ALU  = 3'b000;
    localparam logic [2:0] RS_IMM  = 3'b001;
    localparam logic [2:0] RS_PC4  = 3'b010;
    localparam logic [2:0] RS_MEMR = 3'b011;
    localparam logic [2:0] RS_CRD1 = 3'b100;

    // CSR data select encodings.
    localparam logic [1:0] CS_WRITE = 2'b00;
    localparam logic [1:0] CS_SET   = 2'b01;
    localparam logic [1:0] CS_PC    = 2'b10;
    localparam logic [1:0] CS_CLEAR = 2'b11;

    // Held entry
    logic             r_valid;
    logic [XLEN-1:0]  r_rd1;
    logic [XLEN-1:0]  r_alu;
    logic [XLEN-1:0]  r_crd1;
    logic [XLEN-1:0]  r_pc;
    logic [XLEN-1:0]  r_imm;
    logic [XLEN-1:0]  r_memr;
    logic [RA_W-1:0]  r_rw;
    logic [11:0]      r_crw;
    logic             r_irq;
    logic [2:0]       r_reg_sel;
    logic [1:0]       r_csr_sel;
    logic             r_reg_we;
    logic             r_csr_we;
    logic [CNT_W-1:0] r_instret;

    logic             w_capture;
    logic             w_fire;
    logic             w_sel_legal;
    logic [XLEN-1:0]  w_rf_wdata;
    logic [1:0]       w_csr_sel_eff;
    logic [XLEN-1:0]  w_csr_wdata;

    assign in_ready  = ~r_valid | commit_ready;
    assign w_capture = in_valid & in_ready;
    // A held entry must not retire in the reset cycle. Reset drops the entry
    // without a register-file write and without a count.
    assign w_fire    = r_valid & commit_ready & ~reset;

    // NOTE: Every variable assigned in always_comb gets a default first. A
    // path that leaves a variable unassigned would infer a latch.
    always_comb begin
        w_rf_wdata  = '0;
        w_sel_legal = 1'b1;
        case (r_reg_sel)
            RS_ALU:  w_rf_wdata = r_alu;
            RS_IMM:  w_rf_wdata = r_imm;
            RS_PC4:  w_rf_wdata = r_pc + XLEN'(4);
            RS_MEMR: w_rf_wdata = r_memr;
            RS_CRD1: w_rf_wdata = r_crd1;
            default: w_sel_legal = 1'b0;
        endcase
    end

    // A trap overrides the CSR op and writes the trapping pc into MEPC.
    assign w_csr_sel_eff = r_irq ? CS_PC : r_csr_sel;

    always_comb begin
        w_csr_wdata = '0;
        case (w_csr_sel_eff)
            CS_WRITE: w_csr_wdata = r_rd1;
            CS_SET:   w_csr_wdata = r_rd1 | r_crd1;
            CS_PC:    w_csr_wdata = r_pc;
            CS_CLEAR: w_csr_wdata = r_crd1 & ~r_rd1;
            default:  w_csr_wdata = '0;
        endcase
    end

    // NOTE: Sequential state is written with non-blocking assignments. Every
    // field then samples the values from before the clock edge, whatever the
    // statement order is.
    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: The datapath fields are reset as well as the valid bit.
            // The combinational data and address outputs then read 0 after
            // reset and do not show stale values.
            r_valid   <= 1'b0;
            r_rd1     <= '0;
            r_alu     <= '0;
            r_crd1    <= '0;
            r_pc      <= '0;
            r_imm     <= '0;
            r_memr    <= '0;
            r_rw      <= '0;
            r_crw     <= '0;
            r_irq     <= 1'b0;
            r_reg_sel <= '0;
            r_csr_sel <= '0;
            r_reg_we  <= 1'b0;
            r_csr_we  <= 1'b0;
            r_instret <= '0;
        end else begin
            if (w_capture) begin
                r_valid   <= 1'b1;
                r_rd1     <= in_rd1;
                r_alu     <= in_alu;
                r_crd1    <= in_crd1;
                r_pc      <= in_pc;
                r_imm     <= in_imm;
                r_memr    <= in_memr;
                r_rw      <= in_rw;
                r_crw     <= in_crw;
                r_irq     <= in_irq;
                r_reg_sel <= in_reg_sel;
                r_csr_sel <= in_csr_sel;
                r_reg_we  <= in_reg_we;
                r_csr_we  <= in_csr_we;
            end else if (w_fire) begin
                r_valid <= 1'b0;
            end
            // A trapped instruction does not retire. The counter wraps
            // naturally at 2^CNT_W.
            if (w_fire && !r_irq) begin
                r_instret <= r_instret + CNT_W'(1);
            end
        end
    end

    assign rf_wdata  = w_rf_wdata;
    assign rf_waddr  = r_rw;
    assign rf_we     = w_fire & r_reg_we & ~r_irq & (r_rw != '0) & w_sel_legal;
    assign csr_wdata = w_csr_wdata;
    assign csr_waddr = r_irq ? MEPC_ADDR : r_crw;
    assign csr_we    = w_fire & (r_csr_we | r_irq);

    assign commit_valid = r_valid;
    assign commit_pc    = r_pc;
    assign instret      = r_instret;

endmodule
